// File: rtl/wb_arb_pkg.sv
// Shared definitions for the two-master Wishbone VRAM arbiter: FSM encoding,
// master index constants and the round-robin tie-break helper.
package wb_arb_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OWN0 = 2'd1,
        ST_OWN1 = 2'd2
    } arb_state_e;

    localparam logic M_CPU = 1'b0;
    localparam logic M_VC  = 1'b1;

    // On a simultaneous request the master that did not own the bus last wins.
    function automatic arb_state_e tie_winner(input logic last_owner);
        return (last_owner == M_CPU) ? ST_OWN1 : ST_OWN0;
    endfunction

endpackage

// File: rtl/wb_arb_timeout.sv
// Slave no-response watchdog: counts stalled strobe cycles of the current owner
// and raises a one-cycle expiry pulse when TIMEOUT cycles pass without termination.
module wb_arb_timeout #(
    parameter int TIMEOUT = 255
) (
    input  logic clk,
    input  logic srst,
    input  logic clear,
    input  logic active,
    output logic expire
);

    localparam int CW = $clog2(TIMEOUT + 1);

    logic [CW-1:0] count_reg;
    logic [CW-1:0] count_next;

    always_comb begin
        count_next = count_reg;
        if (clear) begin
            count_next = '0;
        end else if (active) begin
            count_next = count_reg + 1'b1;
        end
    end

    // Fires in the stalled cycle that would bring the count up to TIMEOUT.
    assign expire = active && !clear && (count_reg == CW'(TIMEOUT - 1));

    always_ff @(posedge clk) begin
        if (srst) begin
            count_reg <= '0;
        end else begin
            count_reg <= count_next;
        end
    end

endmodule

// File: rtl/wb_vram_arbiter.sv
// Two-master Wishbone arbiter (CPU data port = master 0, video cache refill = master 1)
// in front of the shared VRAM slave. Optional slave watchdog: define WB_ARB_TIMEOUT_EN.
module wb_vram_arbiter
    import wb_arb_pkg::*;
#(
    parameter int AW      = 32,
    parameter int DW      = 32,
    parameter int TIMEOUT = 255
) (
    input  logic            wb_clk_i,
    input  logic            wb_rst_i,

    input  logic            m0_cyc_i,
    input  logic            m0_stb_i,
    input  logic            m0_we_i,
    input  logic [DW/8-1:0] m0_sel_i,
    input  logic [AW-1:0]   m0_adr_i,
    input  logic [DW-1:0]   m0_dat_i,
    output logic [DW-1:0]   m0_dat_o,
    output logic            m0_ack_o,
    output logic            m0_err_o,
    output logic            m0_rty_o,
    output logic            m0_gnt_o,

    input  logic            m1_cyc_i,
    input  logic            m1_stb_i,
    input  logic            m1_we_i,
    input  logic [DW/8-1:0] m1_sel_i,
    input  logic [AW-1:0]   m1_adr_i,
    input  logic [DW-1:0]   m1_dat_i,
    output logic [DW-1:0]   m1_dat_o,
    output logic            m1_ack_o,
    output logic            m1_err_o,
    output logic            m1_rty_o,
    output logic            m1_gnt_o,

    output logic            s_cyc_o,
    output logic            s_stb_o,
    output logic            s_we_o,
    output logic [DW/8-1:0] s_sel_o,
    output logic [AW-1:0]   s_adr_o,
    output logic [DW-1:0]   s_dat_o,
    input  logic [DW-1:0]   s_dat_i,
    input  logic            s_ack_i,
    input  logic            s_err_i,
    input  logic            s_rty_i
);

    arb_state_e state_reg;
    arb_state_e state_next;
    logic       last_owner_reg;
    logic       last_owner_next;
    logic       gnt0_reg;
    logic       gnt1_reg;

    logic       owner_cyc;
    logic       owner_stb;
    logic       slave_term;
    logic       expire;

    assign slave_term = s_ack_i | s_err_i | s_rty_i;
    assign owner_cyc  = (state_reg == ST_OWN0) ? m0_cyc_i :
                        (state_reg == ST_OWN1) ? m1_cyc_i : 1'b0;
    assign owner_stb  = (state_reg == ST_OWN0) ? m0_stb_i :
                        (state_reg == ST_OWN1) ? m1_stb_i : 1'b0;

`ifdef WB_ARB_TIMEOUT_EN
    logic to_clear;
    logic to_active;

    // Idle cycles hold the counter at zero, so each new grant starts fresh.
    assign to_clear  = (state_reg == ST_IDLE) || slave_term;
    assign to_active = owner_cyc && owner_stb;

    wb_arb_timeout #(
        .TIMEOUT (TIMEOUT)
    ) u_timeout (
        .clk    (wb_clk_i),
        .srst   (wb_rst_i),
        .clear  (to_clear),
        .active (to_active),
        .expire (expire)
    );
`else
    // No watchdog in this build; a silent slave holds the owner indefinitely.
    assign expire = (TIMEOUT < 0);
`endif

    // State register; grants are registered from the next state.
    always_ff @(posedge wb_clk_i) begin
        if (wb_rst_i) begin
            state_reg      <= ST_IDLE;
            last_owner_reg <= M_VC;
            gnt0_reg       <= 1'b0;
            gnt1_reg       <= 1'b0;
        end else begin
            state_reg      <= state_next;
            last_owner_reg <= last_owner_next;
            gnt0_reg       <= (state_next == ST_OWN0);
            gnt1_reg       <= (state_next == ST_OWN1);
        end
    end

    always_comb begin
        state_next      = state_reg;
        last_owner_next = last_owner_reg;
        case (state_reg)
            ST_IDLE: begin
                if (m0_cyc_i && m1_cyc_i) begin
                    state_next = tie_winner(last_owner_reg);
                end else if (m0_cyc_i) begin
                    state_next = ST_OWN0;
                end else if (m1_cyc_i) begin
                    state_next = ST_OWN1;
                end
            end
            ST_OWN0: begin
                if (!m0_cyc_i || expire) begin
                    state_next      = ST_IDLE;
                    last_owner_next = M_CPU;
                end
            end
            ST_OWN1: begin
                if (!m1_cyc_i || expire) begin
                    state_next      = ST_IDLE;
                    last_owner_next = M_VC;
                end
            end
            default: begin
                state_next = ST_IDLE;
            end
        endcase
    end

    // Request mux toward the slave and grant-gated responses back to the masters.
    always_comb begin
        s_cyc_o = 1'b0;
        s_stb_o = 1'b0;
        s_we_o  = 1'b0;
        s_sel_o = '0;
        s_adr_o = '0;
        s_dat_o = '0;
        case (state_reg)
            ST_OWN0: begin
                s_cyc_o = m0_cyc_i;
                s_stb_o = m0_stb_i;
                s_we_o  = m0_we_i;
                s_sel_o = m0_sel_i;
                s_adr_o = m0_adr_i;
                s_dat_o = m0_dat_i;
            end
            ST_OWN1: begin
                s_cyc_o = m1_cyc_i;
                s_stb_o = m1_stb_i;
                s_we_o  = m1_we_i;
                s_sel_o = m1_sel_i;
                s_adr_o = m1_adr_i;
                s_dat_o = m1_dat_i;
            end
            default: begin
                s_cyc_o = 1'b0;
            end
        endcase
        if (expire) begin
            s_cyc_o = 1'b0;
            s_stb_o = 1'b0;
        end

        m0_gnt_o = gnt0_reg;
        m1_gnt_o = gnt1_reg;
        m0_dat_o = s_dat_i;
        m1_dat_o = s_dat_i;
        m0_ack_o = gnt0_reg & s_ack_i;
        m0_err_o = gnt0_reg & (s_err_i | expire);
        m0_rty_o = gnt0_reg & s_rty_i;
        m1_ack_o = gnt1_reg & s_ack_i;
        m1_err_o = gnt1_reg & (s_err_i | expire);
        m1_rty_o = gnt1_reg & s_rty_i;
    end

endmodule
